// File: rtl/axi_to_axi_lite_burst_reflect.sv
// AXI4 to AXI4-Lite converter: splits INCR/FIXED bursts into single Lite beats, reflects IDs, merges B per burst.
// Optional macro AXI2LITE_B_RESP_MERGE_EN: slv B resp becomes the worst resp over all beats of the burst.

module axi_to_axi_lite_burst_reflect_fifo #(
    parameter int unsigned Width       = 12,
    parameter int unsigned Depth       = 4,
    parameter bit          FallThrough = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             test_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_r [Depth];
    logic [PtrW-1:0]  wr_ptr_r;
    logic [PtrW-1:0]  rd_ptr_r;
    logic [CntW-1:0]  cnt_r;
    logic             bypass_s;
    logic             do_push_s;
    logic             do_pop_s;
    logic             unused_test_s;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PtrW'(1);
        end
    endfunction

    assign unused_test_s = test_i;
    assign full_o        = (cnt_r == CntW'(Depth));
    // In fall-through mode an empty FIFO presents the incoming entry immediately.
    assign bypass_s      = FallThrough && (cnt_r == '0) && push_i;
    assign empty_o       = (cnt_r == '0) && !bypass_s;
    assign data_o        = bypass_s ? data_i : mem_r[rd_ptr_r];
    assign do_push_s     = push_i && !full_o && !(bypass_s && pop_i);
    assign do_pop_s      = pop_i && !empty_o && !bypass_s;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + CntW'(1);
                2'b01:   cnt_r <= cnt_r - CntW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end
endmodule

module axi_to_axi_lite_burst_reflect_split #(
    parameter int unsigned AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] slv_addr_i,
    input  logic [7:0]           slv_len_i,
    input  logic [2:0]           slv_size_i,
    input  logic [1:0]           slv_burst_i,
    input  logic [2:0]           slv_prot_i,
    input  logic                 slv_valid_i,
    output logic                 slv_ready_o,
    input  logic                 fifo_full_i,
    output logic                 fifo_push_o,
    output logic [AddrWidth-1:0] mst_addr_o,
    output logic [2:0]           mst_prot_o,
    output logic                 mst_valid_o,
    input  logic                 mst_ready_i
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_e;

    state_e               state_r, state_s;
    logic [AddrWidth-1:0] addr_r, addr_s;
    logic [7:0]           len_r, len_s;
    logic [7:0]           cnt_r, cnt_s;
    logic [2:0]           size_r, size_s;
    logic [1:0]           burst_r, burst_s;
    logic [2:0]           prot_r, prot_s;

    // FIXED keeps the address; INCR (and WRAP) steps to the next size-aligned beat.
    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] a,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
        logic [AddrWidth-1:0] step;
        step = AddrWidth'(1) << size;
        if (burst == 2'b00) begin
            next_addr = a;
        end else begin
            next_addr = (a & ~(step - AddrWidth'(1))) + step;
        end
    endfunction

    assign mst_addr_o  = addr_r;
    assign mst_prot_o  = prot_r;
    assign fifo_push_o = slv_valid_i && slv_ready_o;

    // State and burst context registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
            len_r   <= 8'd0;
            cnt_r   <= 8'd0;
            size_r  <= 3'd0;
            burst_r <= 2'd0;
            prot_r  <= 3'd0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            len_r   <= len_s;
            cnt_r   <= cnt_s;
            size_r  <= size_s;
            burst_r <= burst_s;
            prot_r  <= prot_s;
        end
    end

    // Next-state and handshake logic.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        len_s       = len_r;
        cnt_s       = cnt_r;
        size_s      = size_r;
        burst_s     = burst_r;
        prot_s      = prot_r;
        slv_ready_o = 1'b0;
        mst_valid_o = 1'b0;
        case (state_r)
            ST_IDLE: begin
                slv_ready_o = !fifo_full_i;
                if (slv_valid_i && !fifo_full_i) begin
                    state_s = ST_BURST;
                    addr_s  = slv_addr_i;
                    len_s   = slv_len_i;
                    cnt_s   = 8'd0;
                    size_s  = slv_size_i;
                    burst_s = slv_burst_i;
                    prot_s  = slv_prot_i;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                mst_valid_o = 1'b1;
                if (mst_ready_i) begin
                    if (cnt_r == len_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        cnt_s  = cnt_r + 8'd1;
                        addr_s = next_addr(addr_r, size_r, burst_r);
                    end
                end else begin
                    state_s = ST_BURST;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end
endmodule

module axi_to_axi_lite_burst_reflect #(
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned MaxWriteTxns = 4,
    parameter int unsigned MaxReadTxns  = 4,
    parameter bit          FallThrough  = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   test_i,
    input  logic [IdWidth-1:0]     slv_aw_id_i,
    input  logic [AddrWidth-1:0]   slv_aw_addr_i,
    input  logic [7:0]             slv_aw_len_i,
    input  logic [2:0]             slv_aw_size_i,
    input  logic [1:0]             slv_aw_burst_i,
    input  logic [2:0]             slv_aw_prot_i,
    input  logic                   slv_aw_valid_i,
    output logic                   slv_aw_ready_o,
    input  logic [DataWidth-1:0]   slv_w_data_i,
    input  logic [DataWidth/8-1:0] slv_w_strb_i,
    input  logic                   slv_w_last_i,
    input  logic                   slv_w_valid_i,
    output logic                   slv_w_ready_o,
    output logic [IdWidth-1:0]     slv_b_id_o,
    output logic [1:0]             slv_b_resp_o,
    output logic                   slv_b_valid_o,
    input  logic                   slv_b_ready_i,
    input  logic [IdWidth-1:0]     slv_ar_id_i,
    input  logic [AddrWidth-1:0]   slv_ar_addr_i,
    input  logic [7:0]             slv_ar_len_i,
    input  logic [2:0]             slv_ar_size_i,
    input  logic [1:0]             slv_ar_burst_i,
    input  logic [2:0]             slv_ar_prot_i,
    input  logic                   slv_ar_valid_i,
    output logic                   slv_ar_ready_o,
    output logic [IdWidth-1:0]     slv_r_id_o,
    output logic [DataWidth-1:0]   slv_r_data_o,
    output logic [1:0]             slv_r_resp_o,
    output logic                   slv_r_last_o,
    output logic                   slv_r_valid_o,
    input  logic                   slv_r_ready_i,
    output logic [AddrWidth-1:0]   mst_aw_addr_o,
    output logic [2:0]             mst_aw_prot_o,
    output logic                   mst_aw_valid_o,
    input  logic                   mst_aw_ready_i,
    output logic [DataWidth-1:0]   mst_w_data_o,
    output logic [DataWidth/8-1:0] mst_w_strb_o,
    output logic                   mst_w_valid_o,
    input  logic                   mst_w_ready_i,
    input  logic [1:0]             mst_b_resp_i,
    input  logic                   mst_b_valid_i,
    output logic                   mst_b_ready_o,
    output logic [AddrWidth-1:0]   mst_ar_addr_o,
    output logic [2:0]             mst_ar_prot_o,
    output logic                   mst_ar_valid_o,
    input  logic                   mst_ar_ready_i,
    input  logic [DataWidth-1:0]   mst_r_data_i,
    input  logic [1:0]             mst_r_resp_i,
    input  logic                   mst_r_valid_i,
    output logic                   mst_r_ready_o
);
    localparam int unsigned TrkW = IdWidth + 8;

    logic            wf_push_s, wf_pop_s, wf_full_s, wf_empty_s;
    logic            rf_push_s, rf_pop_s, rf_full_s, rf_empty_s;
    logic [TrkW-1:0] wf_data_s, rf_data_s;
    logic [7:0]      b_cnt_r, r_cnt_r;
    logic            b_final_s, b_hs_s, r_hs_s;
    logic            unused_s;

    assign unused_s = slv_w_last_i;

    axi_to_axi_lite_burst_reflect_fifo #(
        .Width(TrkW), .Depth(MaxWriteTxns), .FallThrough(FallThrough)
    ) i_wr_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .test_i(test_i),
        .push_i(wf_push_s), .data_i({slv_aw_id_i, slv_aw_len_i}), .pop_i(wf_pop_s),
        .data_o(wf_data_s), .full_o(wf_full_s), .empty_o(wf_empty_s)
    );

    axi_to_axi_lite_burst_reflect_fifo #(
        .Width(TrkW), .Depth(MaxReadTxns), .FallThrough(FallThrough)
    ) i_rd_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .test_i(test_i),
        .push_i(rf_push_s), .data_i({slv_ar_id_i, slv_ar_len_i}), .pop_i(rf_pop_s),
        .data_o(rf_data_s), .full_o(rf_full_s), .empty_o(rf_empty_s)
    );

    axi_to_axi_lite_burst_reflect_split #(.AddrWidth(AddrWidth)) i_aw_split (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .slv_addr_i(slv_aw_addr_i), .slv_len_i(slv_aw_len_i), .slv_size_i(slv_aw_size_i),
        .slv_burst_i(slv_aw_burst_i), .slv_prot_i(slv_aw_prot_i),
        .slv_valid_i(slv_aw_valid_i), .slv_ready_o(slv_aw_ready_o),
        .fifo_full_i(wf_full_s), .fifo_push_o(wf_push_s),
        .mst_addr_o(mst_aw_addr_o), .mst_prot_o(mst_aw_prot_o),
        .mst_valid_o(mst_aw_valid_o), .mst_ready_i(mst_aw_ready_i)
    );

    axi_to_axi_lite_burst_reflect_split #(.AddrWidth(AddrWidth)) i_ar_split (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .slv_addr_i(slv_ar_addr_i), .slv_len_i(slv_ar_len_i), .slv_size_i(slv_ar_size_i),
        .slv_burst_i(slv_ar_burst_i), .slv_prot_i(slv_ar_prot_i),
        .slv_valid_i(slv_ar_valid_i), .slv_ready_o(slv_ar_ready_o),
        .fifo_full_i(rf_full_s), .fifo_push_o(rf_push_s),
        .mst_addr_o(mst_ar_addr_o), .mst_prot_o(mst_ar_prot_o),
        .mst_valid_o(mst_ar_valid_o), .mst_ready_i(mst_ar_ready_i)
    );

    assign mst_w_data_o  = slv_w_data_i;
    assign mst_w_strb_o  = slv_w_strb_i;
    assign mst_w_valid_o = slv_w_valid_i;
    assign slv_w_ready_o = mst_w_ready_i;

    assign slv_b_id_o = wf_data_s[TrkW-1:8];
    assign b_final_s  = (b_cnt_r == wf_data_s[7:0]);
    assign b_hs_s     = mst_b_valid_i && mst_b_ready_o;
    assign wf_pop_s   = b_hs_s && b_final_s;

    // Intermediate beats are absorbed; only the final beat is exposed to the slave side.
    always_comb begin
        mst_b_ready_o = 1'b0;
        slv_b_valid_o = 1'b0;
        if (!wf_empty_s) begin
            if (b_final_s) begin
                mst_b_ready_o = slv_b_ready_i;
                slv_b_valid_o = mst_b_valid_i;
            end else begin
                mst_b_ready_o = 1'b1;
            end
        end else begin
            mst_b_ready_o = 1'b0;
        end
    end

    // B and R beat counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_cnt_r <= 8'd0;
            r_cnt_r <= 8'd0;
        end else begin
            if (wf_pop_s) begin
                b_cnt_r <= 8'd0;
            end else if (b_hs_s) begin
                b_cnt_r <= b_cnt_r + 8'd1;
            end
            if (rf_pop_s) begin
                r_cnt_r <= 8'd0;
            end else if (r_hs_s) begin
                r_cnt_r <= r_cnt_r + 8'd1;
            end
        end
    end

`ifdef AXI2LITE_B_RESP_MERGE_EN
    logic [1:0] b_acc_r;

    // DECERR dominates SLVERR dominates OKAY; EXOKAY folds into OKAY.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        if ((a == 2'b11) || (b == 2'b11)) begin
            resp_worst = 2'b11;
        end else if ((a == 2'b10) || (b == 2'b10)) begin
            resp_worst = 2'b10;
        end else begin
            resp_worst = 2'b00;
        end
    endfunction

    // Worst response seen so far in the current burst.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_acc_r <= 2'b00;
        end else if (wf_pop_s) begin
            b_acc_r <= 2'b00;
        end else if (b_hs_s) begin
            b_acc_r <= resp_worst(b_acc_r, mst_b_resp_i);
        end
    end

    assign slv_b_resp_o = resp_worst(b_acc_r, mst_b_resp_i);
`else
    assign slv_b_resp_o = mst_b_resp_i;
`endif

    assign slv_r_valid_o = mst_r_valid_i && !rf_empty_s;
    assign mst_r_ready_o = slv_r_ready_i && !rf_empty_s;
    assign slv_r_id_o    = rf_data_s[TrkW-1:8];
    assign slv_r_data_o  = mst_r_data_i;
    assign slv_r_resp_o  = mst_r_resp_i;
    assign slv_r_last_o  = (r_cnt_r == rf_data_s[7:0]);
    assign r_hs_s        = slv_r_valid_o && slv_r_ready_i;
    assign rf_pop_s      = r_hs_s && slv_r_last_o;
endmodule

// File: tb/tb_axi_to_axi_lite_burst_reflect.sv
// Directed scoreboard bench for axi_to_axi_lite_burst_reflect with a behavioural Lite slave.
// Expected B resp of the merge test follows AXI2LITE_B_RESP_MERGE_EN.

module tb_axi_to_axi_lite_burst_reflect;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        test_i = 1'b0;
    logic [3:0]  slv_aw_id_i = 4'd0;
    logic [31:0] slv_aw_addr_i = 32'd0;
    logic [7:0]  slv_aw_len_i = 8'd0;
    logic [2:0]  slv_aw_size_i = 3'd0;
    logic [1:0]  slv_aw_burst_i = 2'd0;
    logic [2:0]  slv_aw_prot_i = 3'd0;
    logic        slv_aw_valid_i = 1'b0;
    logic        slv_aw_ready_o;
    logic [31:0] slv_w_data_i = 32'd0;
    logic [3:0]  slv_w_strb_i = 4'd0;
    logic        slv_w_last_i = 1'b0;
    logic        slv_w_valid_i = 1'b0;
    logic        slv_w_ready_o;
    logic [3:0]  slv_b_id_o;
    logic [1:0]  slv_b_resp_o;
    logic        slv_b_valid_o;
    logic        slv_b_ready_i = 1'b1;
    logic [3:0]  slv_ar_id_i = 4'd0;
    logic [31:0] slv_ar_addr_i = 32'd0;
    logic [7:0]  slv_ar_len_i = 8'd0;
    logic [2:0]  slv_ar_size_i = 3'd0;
    logic [1:0]  slv_ar_burst_i = 2'd0;
    logic [2:0]  slv_ar_prot_i = 3'd0;
    logic        slv_ar_valid_i = 1'b0;
    logic        slv_ar_ready_o;
    logic [3:0]  slv_r_id_o;
    logic [31:0] slv_r_data_o;
    logic [1:0]  slv_r_resp_o;
    logic        slv_r_last_o;
    logic        slv_r_valid_o;
    logic        slv_r_ready_i = 1'b1;
    logic [31:0] mst_aw_addr_o;
    logic [2:0]  mst_aw_prot_o;
    logic        mst_aw_valid_o;
    logic        mst_aw_ready_i = 1'b1;
    logic [31:0] mst_w_data_o;
    logic [3:0]  mst_w_strb_o;
    logic        mst_w_valid_o;
    logic        mst_w_ready_i = 1'b1;
    logic [1:0]  mst_b_resp_i = 2'd0;
    logic        mst_b_valid_i = 1'b0;
    logic        mst_b_ready_o;
    logic [31:0] mst_ar_addr_o;
    logic [2:0]  mst_ar_prot_o;
    logic        mst_ar_valid_o;
    logic        mst_ar_ready_i = 1'b1;
    logic [31:0] mst_r_data_i = 32'd0;
    logic [1:0]  mst_r_resp_i = 2'd0;
    logic        mst_r_valid_i = 1'b0;
    logic        mst_r_ready_o;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [31:0] RMASK = 32'h5A5A_0000;
`ifdef AXI2LITE_B_RESP_MERGE_EN
    localparam logic [1:0] MERGE_EXP = 2'b10;
`else
    localparam logic [1:0] MERGE_EXP = 2'b00;
`endif

    int tests = 0;
    int fails = 0;
    int pend_b = 0;
    int aw_hs_cnt = 0;
    bit r_en = 1'b1;
    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_ar_q[$];
    logic [35:0] exp_w_q[$];
    logic [5:0]  exp_b_q[$];
    logic [38:0] exp_r_q[$];
    logic [1:0]  b_resp_q[$];
    logic [31:0] pend_r_q[$];

    axi_to_axi_lite_burst_reflect #(.MaxReadTxns(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .test_i(test_i),
        .slv_aw_id_i(slv_aw_id_i), .slv_aw_addr_i(slv_aw_addr_i), .slv_aw_len_i(slv_aw_len_i),
        .slv_aw_size_i(slv_aw_size_i), .slv_aw_burst_i(slv_aw_burst_i), .slv_aw_prot_i(slv_aw_prot_i),
        .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o),
        .slv_w_data_i(slv_w_data_i), .slv_w_strb_i(slv_w_strb_i), .slv_w_last_i(slv_w_last_i),
        .slv_w_valid_i(slv_w_valid_i), .slv_w_ready_o(slv_w_ready_o),
        .slv_b_id_o(slv_b_id_o), .slv_b_resp_o(slv_b_resp_o), .slv_b_valid_o(slv_b_valid_o),
        .slv_b_ready_i(slv_b_ready_i),
        .slv_ar_id_i(slv_ar_id_i), .slv_ar_addr_i(slv_ar_addr_i), .slv_ar_len_i(slv_ar_len_i),
        .slv_ar_size_i(slv_ar_size_i), .slv_ar_burst_i(slv_ar_burst_i), .slv_ar_prot_i(slv_ar_prot_i),
        .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
        .slv_r_id_o(slv_r_id_o), .slv_r_data_o(slv_r_data_o), .slv_r_resp_o(slv_r_resp_o),
        .slv_r_last_o(slv_r_last_o), .slv_r_valid_o(slv_r_valid_o), .slv_r_ready_i(slv_r_ready_i),
        .mst_aw_addr_o(mst_aw_addr_o), .mst_aw_prot_o(mst_aw_prot_o), .mst_aw_valid_o(mst_aw_valid_o),
        .mst_aw_ready_i(mst_aw_ready_i),
        .mst_w_data_o(mst_w_data_o), .mst_w_strb_o(mst_w_strb_o), .mst_w_valid_o(mst_w_valid_o),
        .mst_w_ready_i(mst_w_ready_i),
        .mst_b_resp_i(mst_b_resp_i), .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_o(mst_b_ready_o),
        .mst_ar_addr_o(mst_ar_addr_o), .mst_ar_prot_o(mst_ar_prot_o), .mst_ar_valid_o(mst_ar_valid_o),
        .mst_ar_ready_i(mst_ar_ready_i),
        .mst_r_data_i(mst_r_data_i), .mst_r_resp_i(mst_r_resp_i), .mst_r_valid_i(mst_r_valid_i),
        .mst_r_ready_o(mst_r_ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // AXI beat address: first beat as given, later beats from the aligned start.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [1:0] burst, input int i);
        logic [31:0] step;
        step = 32'd1 << size;
        if (burst == FIXED || i == 0) return a;
        return ((a >> size) << size) + step * 32'(i);
    endfunction

    // Monitor: handshakes are stable at the falling edge and complete at the next rising edge.
    always @(negedge clk) begin
        logic [31:0] ea;
        logic [35:0] ew;
        logic [5:0]  eb;
        logic [38:0] er;
        if (!rst_ni) begin
            pend_b = 0;
            pend_r_q.delete();
        end else begin
            if (mst_aw_valid_o && mst_aw_ready_i) begin
                aw_hs_cnt++;
                pend_b++;
                check("maw_expected", 64'(exp_aw_q.size() != 0), 64'd1);
                if (exp_aw_q.size() != 0) begin
                    ea = exp_aw_q.pop_front();
                    check("maw_addr", 64'(mst_aw_addr_o), 64'(ea));
                end
            end
            if (mst_w_valid_o && mst_w_ready_i) begin
                check("mw_expected", 64'(exp_w_q.size() != 0), 64'd1);
                if (exp_w_q.size() != 0) begin
                    ew = exp_w_q.pop_front();
                    check("mw_data_strb", 64'({mst_w_data_o, mst_w_strb_o}), 64'(ew));
                end
            end
            if (mst_b_valid_i && mst_b_ready_o) begin
                pend_b--;
                if (b_resp_q.size() != 0) void'(b_resp_q.pop_front());
            end
            if (mst_ar_valid_o && mst_ar_ready_i) begin
                check("mar_expected", 64'(exp_ar_q.size() != 0), 64'd1);
                if (exp_ar_q.size() != 0) begin
                    ea = exp_ar_q.pop_front();
                    check("mar_addr", 64'(mst_ar_addr_o), 64'(ea));
                end
                pend_r_q.push_back(mst_ar_addr_o ^ RMASK);
            end
            if (mst_r_valid_i && mst_r_ready_o) void'(pend_r_q.pop_front());
            if (slv_b_valid_o && slv_b_ready_i) begin
                check("sb_expected", 64'(exp_b_q.size() != 0), 64'd1);
                if (exp_b_q.size() != 0) begin
                    eb = exp_b_q.pop_front();
                    check("sb_id_resp", 64'({slv_b_id_o, slv_b_resp_o}), 64'(eb));
                end
            end
            if (slv_r_valid_o && slv_r_ready_i) begin
                check("sr_expected", 64'(exp_r_q.size() != 0), 64'd1);
                if (exp_r_q.size() != 0) begin
                    er = exp_r_q.pop_front();
                    check("sr_id_data_resp_last",
                          64'({slv_r_id_o, slv_r_data_o, slv_r_resp_o, slv_r_last_o}), 64'(er));
                end
            end
        end
    end

    // Lite slave responder: one B per AW beat, R data derived from the beat address.
    always begin
        @(posedge clk);
        #2;
        mst_b_valid_i = (pend_b > 0);
        mst_b_resp_i  = (b_resp_q.size() != 0) ? b_resp_q[0] : 2'b00;
        mst_r_valid_i = r_en && (pend_r_q.size() != 0);
        mst_r_data_i  = (pend_r_q.size() != 0) ? pend_r_q[0] : 32'd0;
        mst_r_resp_i  = 2'b00;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [1:0] bresp);
        bit got = 1'b0;
        for (int i = 0; i <= int'(len); i++) exp_aw_q.push_back(beat_addr(addr, size, burst, i));
        exp_b_q.push_back({id, bresp});
        slv_aw_id_i = id; slv_aw_addr_i = addr; slv_aw_len_i = len;
        slv_aw_size_i = size; slv_aw_burst_i = burst; slv_aw_valid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (slv_aw_ready_o) begin got = 1'b1; break; end
        end
        check("aw_accept", 64'(got), 64'd1);
        tick();
        slv_aw_valid_i = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        bit got = 1'b0;
        exp_w_q.push_back({data, strb});
        slv_w_data_i = data; slv_w_strb_i = strb; slv_w_valid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (slv_w_ready_o) begin got = 1'b1; break; end
        end
        check("w_accept", 64'(got), 64'd1);
        tick();
        slv_w_valid_i = 1'b0;
    endtask

    task automatic push_ar_exp(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] ba;
        for (int i = 0; i <= int'(len); i++) begin
            ba = beat_addr(addr, size, burst, i);
            exp_ar_q.push_back(ba);
            exp_r_q.push_back({id, ba ^ RMASK, 2'b00, (i == int'(len))});
        end
        slv_ar_id_i = id; slv_ar_addr_i = addr; slv_ar_len_i = len;
        slv_ar_size_i = size; slv_ar_burst_i = burst; slv_ar_valid_i = 1'b1;
    endtask

    task automatic wait_ar();
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (slv_ar_ready_o) begin got = 1'b1; break; end
        end
        check("ar_accept", 64'(got), 64'd1);
        tick();
        slv_ar_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (exp_aw_q.size() == 0 && exp_ar_q.size() == 0 && exp_w_q.size() == 0 &&
                exp_b_q.size() == 0 && exp_r_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 64'(done), 64'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit got;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mst_aw_valid", 64'(mst_aw_valid_o), 64'd0);
        check("rst_mst_ar_valid", 64'(mst_ar_valid_o), 64'd0);
        check("rst_slv_b_valid", 64'(slv_b_valid_o), 64'd0);
        check("rst_slv_r_valid", 64'(slv_r_valid_o), 64'd0);
        check("rst_mst_b_ready", 64'(mst_b_ready_o), 64'd0);
        check("rst_mst_r_ready", 64'(mst_r_ready_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Single-beat write.
        send_aw(4'd3, 32'h0000_0100, 8'd0, 3'd2, INCR, 2'b00);
        send_w(32'hDEAD_BEEF, 4'hF);
        drain("drain_single_write");

        // 4-beat INCR read.
        push_ar_exp(4'd5, 32'h0000_1000, 8'd3, 3'd2, INCR);
        wait_ar();
        drain("drain_incr_read");

        // FIXED write, three beats at the same address.
        send_aw(4'd7, 32'h0000_0040, 8'd2, 3'd2, FIXED, 2'b00);
        send_w(32'h1111_0001, 4'h1);
        send_w(32'h2222_0002, 4'h3);
        send_w(32'h3333_0003, 4'hF);
        drain("drain_fixed_write");

        // Unaligned start address realigns on the second beat.
        push_ar_exp(4'd6, 32'h0000_1002, 8'd1, 3'd2, INCR);
        wait_ar();
        drain("drain_unaligned_read");

        // Address wraps modulo 2^32.
        push_ar_exp(4'd2, 32'hFFFF_FFFC, 8'd1, 3'd2, INCR);
        wait_ar();
        drain("drain_addr_wrap_read");

        // Response merge: one SLVERR in the middle of a 4-beat burst.
        b_resp_q = '{2'b00, 2'b10, 2'b00, 2'b00};
        send_aw(4'd9, 32'h0000_0300, 8'd3, 3'd2, INCR, MERGE_EXP);
        for (int i = 0; i < 4; i++) send_w(32'hA000_0000 + 32'(i), 4'hF);
        drain("drain_merge_write");

        // Read tracking FIFO of depth 2 fills while R is stalled.
        r_en = 1'b0;
        push_ar_exp(4'd1, 32'h0000_0200, 8'd0, 3'd2, INCR);
        wait_ar();
        push_ar_exp(4'd2, 32'h0000_0204, 8'd0, 3'd2, INCR);
        wait_ar();
        push_ar_exp(4'd3, 32'h0000_0208, 8'd0, 3'd2, INCR);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("ar_full_ready_low", 64'(slv_ar_ready_o), 64'd0);
        check("r_stalled_no_valid", 64'(slv_r_valid_o), 64'd0);
        r_en = 1'b1;
        wait_ar();
        drain("drain_backpressure");

        // Reset after the second of four write beats.
        base = aw_hs_cnt;
        got = 1'b0;
        send_aw(4'hA, 32'h0000_0500, 8'd3, 3'd2, INCR, 2'b00);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (aw_hs_cnt >= base + 2) begin got = 1'b1; break; end
        end
        check("rst_beat2_reached", 64'(got), 64'd1);
        #2;
        rst_ni = 1'b0;
        @(negedge clk);
        check("midrst_mst_aw_valid", 64'(mst_aw_valid_o), 64'd0);
        check("midrst_mst_ar_valid", 64'(mst_ar_valid_o), 64'd0);
        check("midrst_slv_b_valid", 64'(slv_b_valid_o), 64'd0);
        check("midrst_slv_r_valid", 64'(slv_r_valid_o), 64'd0);
        exp_aw_q.delete();
        exp_b_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_ni = 1'b1;
        @(negedge clk);
        check("postrst_no_beats", 64'(mst_aw_valid_o), 64'd0);
        tick();

        // Normal traffic after reset.
        send_aw(4'hB, 32'h0000_0600, 8'd1, 3'd2, INCR, 2'b00);
        send_w(32'h6060_6060, 4'hF);
        send_w(32'h6464_6464, 4'hF);
        drain("drain_postrst_write");
        push_ar_exp(4'hC, 32'h0000_0700, 8'd1, 3'd2, INCR);
        wait_ar();
        drain("drain_postrst_read");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
